// File: rtl/mmac_sequencer.sv
// Job-level controller for the matrix MAC lane: buffers two square operand matrices, sequences
// clear/enable over k for each output element and streams results out row-major.
module mmac_sequencer #(
  parameter int unsigned M_SIZE    = 4,
  parameter int unsigned VAR_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 2 * VAR_WIDTH + $clog2(M_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [VAR_WIDTH-1:0] in_data_i,
  output logic                 mac_clear_o,
  output logic                 mac_enable_o,
  output logic [VAR_WIDTH-1:0] mac_a_o,
  output logic [VAR_WIDTH-1:0] mac_b_o,
  input  logic [ACC_WIDTH-1:0] mac_acc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned IdxW  = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
  localparam int unsigned NElem = M_SIZE * M_SIZE;
  localparam int unsigned LdW   = $clog2(2 * NElem);

  localparam logic [IdxW-1:0] IdxMax = IdxW'(M_SIZE - 1);
  localparam logic [LdW-1:0]  LdLast = LdW'(2 * NElem - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StClr, StMac, StCapt, StOut} state_e;

  state_e                state_q, state_d;
  logic [LdW-1:0]        ld_cnt_q, ld_cnt_d;
  logic [IdxW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic                  out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  done_q, done_d;
  logic                  load_we;

  logic [VAR_WIDTH-1:0]  a_q [NElem];
  logic [VAR_WIDTH-1:0]  b_q [NElem];

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    done_d       = 1'b0;
    load_we      = 1'b0;

    in_ready_o   = (state_q == StLoad);
    mac_clear_o  = (state_q == StClr);
    mac_enable_o = (state_q == StMac);
    mac_a_o      = mac_enable_o ? a_q[{i_q, k_q}] : '0;
    mac_b_o      = mac_enable_o ? b_q[{k_q, j_q}] : '0;

    // Abort overrides everything, including a result handshake in the same cycle.
    if (abort_i) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d  = StLoad;
            ld_cnt_d = '0;
          end
        end
        StLoad: begin
          if (in_valid_i) begin
            load_we  = 1'b1;
            ld_cnt_d = ld_cnt_q + 1'b1;
            if (ld_cnt_q == LdLast) begin
              state_d = StClr;
              i_d     = '0;
              j_d     = '0;
            end
          end
        end
        StClr: begin
          k_d     = '0;
          state_d = StMac;
        end
        StMac: begin
          k_d = k_q + 1'b1;
          if (k_q == IdxMax) state_d = StCapt;
        end
        StCapt: begin
          out_data_d  = mac_acc_i;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end
        StOut: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            if (i_q == IdxMax && j_q == IdxMax) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              j_d = j_q + 1'b1;
              if (j_q == IdxMax) i_d = i_q + 1'b1;
              state_d = StClr;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ld_cnt_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Top bit of the load counter selects the B half of the stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NElem; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
      end
    end else if (load_we) begin
      if (ld_cnt_q[LdW-1]) b_q[ld_cnt_q[LdW-2:0]] <= in_data_i;
      else                 a_q[ld_cnt_q[LdW-2:0]] <= in_data_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_valid_q && (i_q == IdxMax) && (j_q == IdxMax);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;

endmodule
